// File: rtl/mem_stage_ws.sv
// rtl/mem_stage_ws.sv - Y86-64 memory stage with wait states, bounds check and W register
// Sits between the execute-stage M register and writeback; stalls upstream via m_busy.
module mem_stage_ws #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [DATA_W-1:0] M_valE,
    input  logic              W_stall,
    output logic              m_busy,
    output logic [1:0]        m_stat,
    output logic [DATA_W-1:0] m_valM,
    output logic [1:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM
);

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_ADR = 2'b11;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam int                CNT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
    localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              is_read;
    logic              is_write;
    logic              is_mem;
    logic [DATA_W-1:0] addr;
    logic              in_range;
    logic              qualified;
    logic              final_cyc;
    logic              do_write;
    logic [ADDR_W-1:0] addr_idx;

    logic [1:0]        w_stat_q,  w_stat_d;
    logic [3:0]        w_icode_q, w_icode_d;
    logic [3:0]        w_dste_q,  w_dste_d;
    logic [3:0]        w_dstm_q,  w_dstm_d;
    logic [DATA_W-1:0] w_vale_q,  w_vale_d;
    logic [DATA_W-1:0] w_valm_q,  w_valm_d;

    always_comb begin
        is_read  = (M_icode == I_MRMOVQ) || (M_icode == I_RET) || (M_icode == I_POPQ);
        is_write = (M_icode == I_RMMOVQ) || (M_icode == I_CALL) || (M_icode == I_PUSHQ);
        is_mem   = is_read || is_write;
        addr     = ((M_icode == I_RET) || (M_icode == I_POPQ)) ? M_valA : M_valE;
    end

    // Full-width compare so high address bits can never alias into the array.
    assign in_range  = (addr < DEPTH_W);
    assign addr_idx  = addr[ADDR_W-1:0];
    assign qualified = is_mem && (M_stat == STAT_AOK) && in_range;
    assign m_stat    = (is_mem && !in_range) ? STAT_ADR : M_stat;
    assign m_valM    = (is_read && in_range) ? mem_q[addr_idx] : '0;

    assign final_cyc = ((state_q == S_IDLE) && (MEM_LAT == 1)) ||
                       ((state_q == S_WAIT) && (cnt_q == '0));
    assign m_busy    = qualified && !final_cyc;
    assign do_write  = !rst && !W_stall && qualified && is_write && final_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (!W_stall) begin
            case (state_q)
                S_IDLE: begin
                    if (qualified && (MEM_LAT > 1)) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Contents survive reset; only the access sequencing is cleared.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[addr_idx] <= M_valA;
        end
    end

    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        if (!W_stall) begin
            if (m_busy) begin
                w_stat_d  = STAT_AOK;
                w_icode_d = I_NOP;
                w_dste_d  = R_NONE;
                w_dstm_d  = R_NONE;
                w_vale_d  = '0;
                w_valm_d  = '0;
            end else begin
                w_stat_d  = m_stat;
                w_icode_d = M_icode;
                w_dste_d  = M_dstE;
                w_dstm_d  = M_dstM;
                w_vale_d  = M_valE;
                w_valm_d  = m_valM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_stat_q  <= STAT_AOK;
            w_icode_q <= I_NOP;
            w_dste_q  <= R_NONE;
            w_dstm_q  <= R_NONE;
            w_vale_q  <= '0;
            w_valm_q  <= '0;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
        end
    end

    assign W_stat  = w_stat_q;
    assign W_icode = w_icode_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;

endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
- Parametrised Y86-64 pipeline memory stage: M-register inputs in, W-register outputs out.
- Adds configurable data width, memory depth and access latency (wait states) with a stall handshake to the upstream pipeline.
- Adds correct per-opcode address bounds checking, W-register bubble/stall control and synchronous reset.
- Sits between the execute-stage M register and the writeback stage.

Parameters:
- DATA_W, 64, width of valA/valE/valM and memory words
- DEPTH, 256, number of memory words; legal addresses 0..DEPTH-1
- ADDR_W, $clog2(DEPTH), index width used into the array
- MEM_LAT, 2, cycles per memory access (>=1); 1 means zero wait states

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- M_stat  in  2  status: 00 AOK, 01 HLT, 10 INS, 11 ADR
- M_icode  in  4  instruction code
- M_dstE  in  4  E destination register
- M_dstM  in  4  M destination register
- M_valA  in  DATA_W  store data / ret-pop address
- M_valE  in  DATA_W  computed address / ALU result
- W_stall  in  1  hold W register and freeze stage
- m_busy  out  1  stage needs more cycles; upstream holds M inputs
- m_stat  out  2  combinational status after bounds check
- m_valM  out  DATA_W  combinational read data
- W_stat  out  2  W register status
- W_icode  out  4  W register icode
- W_dstE  out  4  W register dstE
- W_dstM  out  4  W register dstM
- W_valE  out  DATA_W  W register valE
- W_valM  out  DATA_W  W register valM

Behaviour:
- Opcode table (address source):
  - Reads: 5 mrmovq (valE), 9 ret (valA), B popq (valA).
  - Writes of valA: 4 rmmovq (valE), 8 call (valE), A pushq (valE).
  - All other icodes do not access memory.
- Address check: the full DATA_W address is compared against DEPTH, so there is no truncation aliasing.
  - Memory op with address >= DEPTH: m_stat=11, no write, m_valM=0.
  - Otherwise m_stat=M_stat.
- Access is qualified: icode is a memory op AND M_stat==00 AND address in range. Unqualified instructions complete in 1 cycle.
- FSM:
  - IDLE: qualified access with MEM_LAT>1 -> WAIT, counter=MEM_LAT-2.
  - WAIT: counter decrements each non-stalled cycle. At 0 and not stalled -> IDLE.
  - Final cycle = IDLE with MEM_LAT==1, or WAIT with counter==0.
  - IDLE with an unqualified instruction, or MEM_LAT==1: stays IDLE.
- m_busy = qualified access AND not final cycle. It is combinational and high for exactly MEM_LAT-1 cycles per access when W_stall=0.
- Upstream contract: M_* are held stable while m_busy=1. The stage does not re-sample them mid-access.
- Write commit: the array is written only on the final-cycle edge with W_stall=0. Exactly one write per access.
- m_valM:
  - Equals mem[addr] whenever a qualified read is presented (stable throughout the access).
  - Is 0 for non-read icodes and for out-of-range reads.
- W register update on each edge, in priority order:
  - rst: W_stat=00, W_icode=1 (nop), W_dstE=W_dstM=F, W_valE=W_valM=0.
  - Else W_stall=1: all W outputs hold; FSM and counter hold; no write.
  - Else m_busy=1: bubble is loaded (stat 00, icode 1, dstE/dstM F, vals 0).
  - Else: loads m_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM.
- Reset mid-access: FSM -> IDLE, counter -> 0, pending write discarded. Memory contents are not cleared by reset.
- Reset values: m_busy=0 while inputs are unqualified. Other W outputs as listed above.
- Back-to-back accesses: the next access starts in the cycle after the final cycle, with no idle gap.

Test Plan:
- MEM_LAT=3, rmmovq valE=0x10 valA=0xDEAD -> m_busy=1 for 2 cycles, W gets 2 bubbles (icode 1), then W_icode=4. mem[0x10]=0xDEAD written once.
- Then mrmovq valE=0x10 dstM=3 -> m_busy=1 for 2 cycles, then W_valM=0xDEAD, W_dstM=3.
- popq valA=0x100 (DEPTH=256) -> m_stat=11 immediately, m_busy=0, no array access, W_stat=11 next edge, W_valM=0.
- Address 0x1_0000_0010 with DEPTH=256 -> ADR, mem[0x10] unchanged (no aliasing).
- W_stall=1 held 2 cycles on the final cycle of a pushq valE=0x20 valA=5 -> W outputs frozen, mem[0x20] written once only after the stall drops.
- rst=1 in the WAIT cycle of a call -> W_icode=1, W_stat=00, m_busy drops with inputs changed to nop, target word keeps its old value.
- MEM_LAT=1, alternating rmmovq and mrmovq to address 7 every cycle -> m_busy never asserts, and the read sees the value written on the prior edge.
